// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: program counter, instruction-memory addressing
// and the IF/ID pipeline register feeding the control unit.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        PCsrc_i,
    input  logic        JALR_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] ALUout_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_d_o,
    output logic [31:0] pc_d_o,
    output logic [31:0] pcplus4_d_o,
    output logic        valid_d_o,
    output logic        misalign_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;

    logic [31:0] tgt;
    logic [31:0] applied_tgt;
    logic [31:0] pc_plus4;

    // JALR clears bit 0 before the alignment check, so only bit 1 can flag there.
    assign tgt         = JALR_i ? (ALUout_i & ~32'd1) : branch_target_i;
    assign applied_tgt = {tgt[31:2], 2'b00};
    assign pc_plus4    = pc_q + 32'd4;

    // Redirect outranks stall; a stall freezes both PC and IF/ID.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        ifid_pc_d  = ifid_pc_q;
        ifid_pc4_d = ifid_pc4_q;
        valid_d    = valid_q;
        misalign_d = PCsrc_i & (tgt[1:0] != 2'b00);
        if (PCsrc_i) begin
            pc_d    = applied_tgt;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            pc_d       = pc_plus4;
            instr_d    = imem_rdata_i;
            ifid_pc_d  = pc_q;
            ifid_pc4_d = pc_plus4;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            ifid_pc_q  <= 32'd0;
            ifid_pc4_q <= 32'd0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            ifid_pc_q  <= ifid_pc_d;
            ifid_pc4_q <= ifid_pc4_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign instr_d_o   = instr_q;
    assign pc_d_o      = ifid_pc_q;
    assign pcplus4_d_o = ifid_pc4_q;
    assign valid_d_o   = valid_q;
    assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a driver pushes expected IF/ID contents from a
// simple reference model, a monitor pops and compares after every clock edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst, stall, PCsrc, JALR;
    logic [31:0] branch_target, ALUout;
    logic [31:0] imem_addr, imem_rdata, instr_d, pc_d, pcplus4_d;
    logic        valid_d, misalign;

    logic        rst_w;
    logic [31:0] imem_addr_w, imem_rdata_w, instr_d_w, pc_d_w, pcplus4_d_w;
    logic        valid_d_w, misalign_w;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] pc4;
        logic [31:0] addr;
        logic        valid;
        logic        mis;
    } exp_t;
    exp_t q[$];
    exp_t e;

    // reference model state
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
    logic        m_valid, m_mis;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a >> 2) + 32'h100;
    endfunction

    assign imem_rdata   = mem(imem_addr);
    assign imem_rdata_w = mem(imem_addr_w);

    fetch_stage dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .PCsrc_i(PCsrc), .JALR_i(JALR),
        .branch_target_i(branch_target), .ALUout_i(ALUout),
        .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
        .instr_d_o(instr_d), .pc_d_o(pc_d), .pcplus4_d_o(pcplus4_d),
        .valid_d_o(valid_d), .misalign_o(misalign)
    );

    fetch_stage #(.RESET_PC(WRAP_PC)) dut_w (
        .clk_i(clk), .rst_i(rst_w), .stall_i(1'b0), .PCsrc_i(1'b0), .JALR_i(1'b0),
        .branch_target_i(32'd0), .ALUout_i(32'd0),
        .imem_addr_o(imem_addr_w), .imem_rdata_i(imem_rdata_w),
        .instr_d_o(instr_d_w), .pc_d_o(pc_d_w), .pcplus4_d_o(pcplus4_d_w),
        .valid_d_o(valid_d_w), .misalign_o(misalign_w)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_instr = NOP; m_pcd = 32'd0; m_pc4 = 32'd0;
        m_valid = 1'b0; m_mis = 1'b0;
    endtask

    // One clock: apply inputs, advance the model by one edge, queue its result.
    task automatic cycle(input logic s, input logic p, input logic j,
                         input logic [31:0] bt, input logic [31:0] alu);
        logic [31:0] t;
        exp_t x;
        stall = s; PCsrc = p; JALR = j; branch_target = bt; ALUout = alu;
        t = j ? {alu[31:1], 1'b0} : bt;
        m_mis = 1'b0;
        if (p) begin
            m_mis   = (t % 4) != 0;
            m_pc    = (t / 4) * 4;
            m_instr = NOP;
            m_valid = 1'b0;
        end else if (!s) begin
            m_instr = mem(m_pc);
            m_pcd   = m_pc;
            m_pc4   = m_pc + 4;
            m_valid = 1'b1;
            m_pc    = m_pc + 4;
        end
        x.instr = m_instr; x.pcd = m_pcd; x.pc4 = m_pc4; x.addr = m_pc;
        x.valid = m_valid; x.mis = m_mis;
        q.push_back(x);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && q.size() > 0) begin
            e = q.pop_front();
            check32("instr_d",   instr_d,   e.instr);
            check32("pc_d",      pc_d,      e.pcd);
            check32("pcplus4_d", pcplus4_d, e.pc4);
            check32("valid_d",   {31'd0, valid_d},  {31'd0, e.valid});
            check32("misalign",  {31'd0, misalign}, {31'd0, e.mis});
            check32("imem_addr", imem_addr, e.addr);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rst_w = 1'b1;
        stall = 1'b0; PCsrc = 1'b0; JALR = 1'b0; branch_target = 32'd0; ALUout = 32'd0;
        model_reset();
        #3;
        check32("rst_imem_addr", imem_addr, 32'd0);
        check32("rst_instr_d",   instr_d,   NOP);
        check32("rst_pc_d",      pc_d,      32'd0);
        check32("rst_valid_d",   {31'd0, valid_d},  32'd0);
        check32("rst_misalign",  {31'd0, misalign}, 32'd0);
        check32("wrap_rst_addr", imem_addr_w, WRAP_PC);

        // wrap-around on the second instance
        @(negedge clk); #1;
        rst_w = 1'b0;
        @(negedge clk);
        check32("wrap_addr1", imem_addr_w, 32'hFFFF_FFFC);
        @(negedge clk);
        check32("wrap_addr2", imem_addr_w, 32'h0000_0000);
        check32("wrap_pc_d",  pc_d_w,      32'hFFFF_FFFC);
        check32("wrap_instr", instr_d_w,   mem(32'hFFFF_FFFC));
        #2;
        rst_w = 1'b1;
        #1;
        check32("wrap_async_addr",  imem_addr_w, WRAP_PC);
        check32("wrap_async_valid", {31'd0, valid_d_w}, 32'd0);
        check32("wrap_async_pc_d",  pc_d_w, 32'd0);
        #1;

        // main instance: release and run sequentially
        @(negedge clk); #1;
        rst = 1'b0;
        model_reset();
        repeat (4) cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 32'h40, 0);            // branch redirect from 0x10
        repeat (2) cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 32'h18, 0);
        repeat (2) cycle(0, 0, 0, 0, 0);      // pc now 0x20, pc_d 0x1C
        repeat (3) cycle(1, 0, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 1, 32'h1234, 32'h83);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 1, 32'h1234, 32'h81);
        cycle(0, 1, 1, 32'h1234, 32'h86);
        repeat (2) cycle(0, 0, 0, 0, 0);
        cycle(1, 1, 0, 32'h200, 32'h7);       // redirect beats stall
        repeat (2) cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 32'h202, 0);           // misaligned branch target
        cycle(0, 0, 1, 32'h55, 32'h99);       // JALR ignored without PCsrc

        // async reset mid-cycle with a pending redirect and stall
        stall = 1'b1; PCsrc = 1'b1; branch_target = 32'h300;
        #1;
        rst = 1'b1;
        #1;
        check32("async_imem_addr", imem_addr, 32'd0);
        check32("async_instr_d",   instr_d,   NOP);
        check32("async_pc_d",      pc_d,      32'd0);
        check32("async_pcplus4_d", pcplus4_d, 32'd0);
        check32("async_valid_d",   {31'd0, valid_d},  32'd0);
        q.delete();
        @(negedge clk); #1;
        rst = 1'b0;
        model_reset();
        cycle(0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            logic s, p, j;
            logic [31:0] bt, alu;
            s   = ($urandom_range(0, 3) == 0);
            p   = ($urandom_range(0, 5) == 0);
            j   = $urandom_range(0, 1);
            bt  = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h3FF);
            alu = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h3FF);
            cycle(s, p, j, bt, alu);
        end
        cycle(0, 0, 0, 0, 0);

        check32("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
